// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: synchronises sig_in, measures its period and high time,
// and reports lock once the frequency is stable and loss when edges stop arriving.
module clk_div_monitor #(
  parameter int  CLK_DIV  = 10,
  parameter int  TOL      = 1,
  parameter int  LOCK_CNT = 4,
  parameter int  TIMEOUT  = 4 * CLK_DIV,
  parameter int  TPD      = 1,
  localparam int CW       = $clog2(TIMEOUT + 1)
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          sig_in,
  output logic          edge_strb,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          period_vld,
  output logic          locked,
  output logic          lost
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_e;

  localparam int            GW         = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DIV_C      = CW'(CLK_DIV);
  localparam logic [CW-1:0] TOL_C      = CW'(TOL);
  localparam logic [GW-1:0] LOCK_C     = GW'(LOCK_CNT);

  // TPD only models a register delay in behavioural sims; these flops carry none.
  if (TPD < 0) begin : g_tpd_invalid
  end

  logic          sync1_q, sync2_q, s_dly_q;
  logic          rise, timeout_hit, measuring, good;
  logic [CW-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CW-1:0] meas_period, period_err;
  logic [GW-1:0] gcnt_q, gcnt_d, gcnt_inc;
  state_e        state_q, state_d;
  logic          edge_strb_q, edge_strb_d, period_vld_q, period_vld_d;
  logic          locked_q, locked_d, lost_q, lost_d;
  logic [CW-1:0] period_q, period_d, high_time_q, high_time_d;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      s_dly_q <= sync2_q;
    end
  end

  assign rise        = sync2_q & ~s_dly_q;
  assign timeout_hit = ~rise & (cnt_q == TIMEOUT_M1);
  assign measuring   = (state_q == ST_MEASURE) | (state_q == ST_LOCKED);
  assign meas_period = cnt_q + CW'(1);
  assign period_err  = (meas_period >= DIV_C) ? (meas_period - DIV_C) : (DIV_C - meas_period);
  assign good        = (period_err <= TOL_C);
  assign gcnt_inc    = (gcnt_q == LOCK_C) ? gcnt_q : (gcnt_q + GW'(1));

  // The rise cycle is itself high, so the high-time count restarts at one.
  always_comb begin
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    gcnt_d = gcnt_q;
    if (rise) begin
      cnt_d  = '0;
      hcnt_d = CW'(1);
    end else begin
      if (cnt_q != TIMEOUT_C) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
      if (sync2_q && (hcnt_q != TIMEOUT_C)) begin
        hcnt_d = hcnt_q + CW'(1);
      end else begin
        hcnt_d = hcnt_q;
      end
    end
    if (rise && measuring && good) begin
      gcnt_d = gcnt_inc;
    end else if (rise || timeout_hit) begin
      gcnt_d = '0;
    end else begin
      gcnt_d = gcnt_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q  <= '0;
      hcnt_q <= '0;
      gcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
      gcnt_q <= gcnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // A rise always takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end else if (timeout_hit) begin
          state_d = ST_LOST;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_MEASURE: begin
        if (rise && good && (gcnt_inc == LOCK_C)) begin
          state_d = ST_LOCKED;
        end else if (timeout_hit) begin
          state_d = ST_LOST;
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        if (rise && !good) begin
          state_d = ST_MEASURE;
        end else if (timeout_hit) begin
          state_d = ST_LOST;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOST: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end else begin
          state_d = ST_LOST;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    edge_strb_d  = rise;
    period_vld_d = rise & measuring;
    if (rise && measuring) begin
      period_d    = meas_period;
      high_time_d = hcnt_q;
    end else begin
      period_d    = period_q;
      high_time_d = high_time_q;
    end
    locked_d = (state_d == ST_LOCKED);
    lost_d   = (state_d == ST_LOST);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      edge_strb_q  <= 1'b0;
      period_vld_q <= 1'b0;
      period_q     <= '0;
      high_time_q  <= '0;
      locked_q     <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      edge_strb_q  <= edge_strb_d;
      period_vld_q <= period_vld_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      locked_q     <= locked_d;
      lost_q       <= lost_d;
    end
  end

  assign edge_strb  = edge_strb_q;
  assign period_vld = period_vld_q;
  assign period     = period_q;
  assign high_time  = high_time_q;
  assign locked     = locked_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: a table of waveform segments with hand-derived end
// results, plus a timestamp-based reference model checked every cycle.
module tb_clk_div_monitor;

  localparam int CLK_DIV  = 10;
  localparam int TOL      = 1;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 40;
  localparam int CW       = 6;

  localparam int OP_SEG  = 0;
  localparam int OP_LOST = 1;
  localparam int OP_RST  = 2;

  localparam int M_SEARCH  = 0;
  localparam int M_MEASURE = 1;
  localparam int M_LOCKED  = 2;
  localparam int M_LOST    = 3;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          sig_in;
  logic          edge_strb, period_vld, locked, lost;
  logic [CW-1:0] period, high_time;

  clk_div_monitor #(
    .CLK_DIV(CLK_DIV), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .TPD(1)
  ) dut (
    .clk_in(clk_in), .reset(reset), .sig_in(sig_in),
    .edge_strb(edge_strb), .period(period), .high_time(high_time),
    .period_vld(period_vld), .locked(locked), .lost(lost)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int op;
    int hi;
    int lo;
    int reps;
    int e_per;
    int e_ht;
    int e_lock;
    int e_lost;
    int e_lock_strb;
  } vec_t;

  vec_t tbl[14];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: sampled sig_in history plus rise timestamps
  bit xh[128];
  int mn = 8;
  int anchor = 8;
  int mode = M_SEARCH;
  int gcnt = 0;
  int e_strb = 0, e_vld = 0, e_per = 0, e_ht = 0, e_lock = 0, e_lost = 0;

  int last_strb_cyc = 0;
  int after_lost_pending = 0;
  int prev_locked = 0;
  int strbs_since_rst = 0;
  int lock_strb = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_update(input logic sv, input logic rv);
    int sum;
    int d;
    mn++;
    xh[mn % 128] = sv;
    if (rv) begin
      xh[mn % 128] = 1'b0;
      xh[(mn - 1) % 128] = 1'b0;
      xh[(mn - 2) % 128] = 1'b0;
      mode = M_SEARCH; gcnt = 0; anchor = mn;
      e_strb = 0; e_vld = 0; e_per = 0; e_ht = 0; e_lock = 0; e_lost = 0;
    end else begin
      e_strb = (xh[(mn - 2) % 128] && !xh[(mn - 3) % 128]) ? 1 : 0;
      e_vld  = 0;
      if (e_strb == 1) begin
        if (mode == M_MEASURE || mode == M_LOCKED) begin
          e_vld = 1;
          e_per = mn - anchor;
          sum = 0;
          for (int i = anchor - 2; i <= mn - 3; i++) sum = sum + int'(xh[i % 128]);
          e_ht = sum;
          d = e_per - CLK_DIV;
          if (d < 0) d = -d;
          if (d <= TOL) gcnt = (gcnt < LOCK_CNT) ? gcnt + 1 : gcnt;
          else gcnt = 0;
          mode = (gcnt == LOCK_CNT) ? M_LOCKED : M_MEASURE;
        end else begin
          mode = M_MEASURE;
          gcnt = 0;
        end
        anchor = mn;
      end else if ((mn - anchor == TIMEOUT) && mode != M_LOST) begin
        mode = M_LOST;
        gcnt = 0;
      end
      e_lock = (mode == M_LOCKED) ? 1 : 0;
      e_lost = (mode == M_LOST) ? 1 : 0;
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    cyc++;
    model_update(sig_in, reset);
    @(negedge clk_in);
    chk("edge_strb", int'(edge_strb), e_strb);
    chk("period_vld", int'(period_vld), e_vld);
    chk("period", int'(period), e_per);
    chk("high_time", int'(high_time), e_ht);
    chk("locked", int'(locked), e_lock);
    chk("lost", int'(lost), e_lost);
    if (edge_strb) begin
      if (after_lost_pending == 1) begin
        chk("vld_after_lost", int'(period_vld), 0);
        chk("lost_cleared", int'(lost), 0);
        after_lost_pending = 0;
      end
      last_strb_cyc = cyc;
      strbs_since_rst++;
    end
    if (lost) after_lost_pending = 1;
    if (locked && prev_locked == 0 && lock_strb == 0) lock_strb = strbs_since_rst;
    prev_locked = int'(locked);
  endtask

  task automatic run_period(input int hi, input int lo, input int rst_at);
    for (int c = 0; c < hi + lo; c++) begin
      sig_in = (c < hi) ? 1'b1 : 1'b0;
      reset  = (c == rst_at) ? 1'b1 : 1'b0;
      step();
    end
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_edge_strb"}, int'(edge_strb), 0);
    chk({tag, "_period_vld"}, int'(period_vld), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high_time"}, int'(high_time), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_lost"}, int'(lost), 0);
  endtask

  initial begin
    int waited;
    int hi, lo, rst_at;

    //         op       hi  lo reps per ht lock lost lockstrb
    tbl[0]  = '{OP_SEG,  5,  5, 6, 10, 5, 1, 0, 0};
    tbl[1]  = '{OP_SEG,  5,  6, 3, 11, 5, 1, 0, 0};
    tbl[2]  = '{OP_SEG,  6,  6, 2, 12, 6, 0, 0, 0};
    tbl[3]  = '{OP_SEG,  5,  5, 5, 10, 5, 1, 0, 0};
    tbl[4]  = '{OP_SEG,  2,  8, 3, 10, 2, 1, 0, 0};
    tbl[5]  = '{OP_SEG,  2,  3, 1, 10, 2, 1, 0, 0};
    tbl[6]  = '{OP_SEG,  1,  4, 1,  5, 2, 0, 0, 0};
    tbl[7]  = '{OP_SEG,  2,  8, 5, 10, 2, 1, 0, 0};
    tbl[8]  = '{OP_LOST, 0,  0, 0,  0, 0, 0, 1, 0};
    tbl[9]  = '{OP_SEG,  5, 35, 2, 40, 5, 0, 0, 0};
    tbl[10] = '{OP_SEG,  5,  5, 5, 10, 5, 1, 0, 0};
    tbl[11] = '{OP_RST,  0,  0, 0,  0, 0, 0, 0, 0};
    tbl[12] = '{OP_SEG,  5,  5, 6, 10, 5, 1, 0, 5};
    tbl[13] = '{OP_SEG,  5, 36, 2, 10, 5, 0, 0, 0};

    sig_in = 1'b0;
    reset  = 1'b1;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;

    for (int k = 0; k < 14; k++) begin
      if (tbl[k].op == OP_SEG) begin
        for (int r = 0; r < tbl[k].reps; r++) run_period(tbl[k].hi, tbl[k].lo, -1);
        chk($sformatf("tbl%0d_period", k), int'(period), tbl[k].e_per);
        chk($sformatf("tbl%0d_high_time", k), int'(high_time), tbl[k].e_ht);
        chk($sformatf("tbl%0d_locked", k), int'(locked), tbl[k].e_lock);
        chk($sformatf("tbl%0d_lost", k), int'(lost), tbl[k].e_lost);
        if (tbl[k].e_lock_strb != 0)
          chk($sformatf("tbl%0d_lock_after_strbs", k), lock_strb, tbl[k].e_lock_strb);
      end else if (tbl[k].op == OP_LOST) begin
        sig_in = 1'b0;
        waited = 0;
        while (!lost && waited < 100) begin
          step();
          waited++;
        end
        if (!lost) chk("lost_wait_expired", 0, 1);
        chk("lost_delay", cyc - last_strb_cyc, TIMEOUT);
        chk("lost_locked", int'(locked), 0);
      end else begin
        sig_in = 1'b0;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        chk_all_zero("midreset");
        strbs_since_rst = 0;
        lock_strb = 0;
      end
    end

    // randomized periods, occasional long gaps and mid-period resets
    for (int i = 0; i < 150; i++) begin
      hi = int'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) lo = int'($urandom_range(30, 45));
      else lo = 10 - hi + int'($urandom_range(0, 4)) - 2;
      if (lo < 1) lo = 1;
      rst_at = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, hi + lo - 1)) : -1;
      run_period(hi, lo, rst_at);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
